// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv32_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4,
    FAULT = 3'd5
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10
  } fault_cause_t;

  // Instructions are word aligned: any set bit under this mask is a fault.
  localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & INSTR_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting on a memory response; flags when the limit is hit.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + (CNT_W + 1)'(1);

  // Expiry is judged on the value the current waiting cycle would bring the count to,
  // so a limit of N ends the wait after exactly N cycles. Zero disables it.
  assign expired = (TIMEOUT_CYCLES != 0) && (count_inc == LIMIT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory reads handed to decode over valid/ready.
module fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_en,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  fetch_state_t    state, state_next;
  fault_cause_t    cause, cause_next;
  logic [XLEN-1:0] instr_q, pc_q;
  logic            cnt_clear, cnt_en, expired;
  logic            capture, latch_pc, handoff;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(expired)
  );

  always_comb begin
    state_next = state;
    cause_next = cause;
    mem_req    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    capture    = 1'b0;
    latch_pc   = 1'b0;
    handoff    = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        // A flush means pc_in is changing this cycle, so nothing is issued.
        if (!flush) begin
          if (is_misaligned(pc_in[1:0])) begin
            state_next = FAULT;
            cause_next = FC_MISALIGN;
          end else begin
            mem_req = 1'b1;
            if (mem_gnt) begin
              latch_pc   = 1'b1;
              cnt_clear  = 1'b1;
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          if (flush) begin
            state_next = REQ;
          end else begin
            capture    = 1'b1;
            state_next = VALID;
          end
        end else begin
          cnt_en = 1'b1;
          if (expired) begin
            state_next = FAULT;
            cause_next = FC_TIMEOUT;
          end else if (flush) begin
            state_next = DRAIN;
          end
        end
      end
      VALID: begin
        if (flush) begin
          state_next = REQ;
        end else if (instr_ready) begin
          handoff    = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        // The abandoned response must still be absorbed before a new request.
        if (mem_rvalid) begin
          state_next = REQ;
        end else begin
          cnt_en = 1'b1;
          if (expired) begin
            state_next = FAULT;
            cause_next = FC_TIMEOUT;
          end
        end
      end
      FAULT: begin
        if (flush) begin
          state_next = REQ;
          cause_next = FC_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cause   <= FC_NONE;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state <= state_next;
      cause <= cause_next;
      if (capture) begin
        instr_q <= mem_rdata;
      end
      if (latch_pc) begin
        pc_q <= pc_in;
      end
    end
  end

  assign pc_en       = handoff | flush;
  assign mem_addr    = pc_in;
  assign instr_valid = (state == VALID);
  assign fetch_fault = (state == FAULT);
  assign fault_cause = cause;
  assign instr_out   = instr_q;
  assign instr_pc    = pc_q;

endmodule
